pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/otter_pkg.sv | 31 +++
 rtl/branch_cond_gen.sv | 24 ++
 rtl/pc_sequencer.sv | 96 +++++++++
 tb/tb_pc_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER PC sequencer: FSM states, opcodes,
// next-PC select encoding and branch funct3 codes.
package otter_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_WB    = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    PCSRC_PC4    = 2'b00,
    PCSRC_JALR   = 2'b01,
    PCSRC_BRANCH = 2'b10,
    PCSRC_JAL    = 2'b11
  } pc_src_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_cond_gen.sv
// Branch condition evaluation for conditional branches, selected by funct3.
module branch_cond_gen
  import otter_pkg::*;
(
  input  logic [31:0] RS1,
  input  logic [31:0] RS2,
  input  logic [2:0]  FUNCT3,
  output logic        br_taken
);

  always_comb begin
    br_taken = 1'b0;
    case (FUNCT3)
      F3_BEQ:  br_taken = (RS1 == RS2);
      F3_BNE:  br_taken = (RS1 != RS2);
      F3_BLT:  br_taken = ($signed(RS1) <  $signed(RS2));
      F3_BGE:  br_taken = ($signed(RS1) >= $signed(RS2));
      F3_BLTU: br_taken = (RS1 <  RS2);
      F3_BGEU: br_taken = (RS1 >= RS2);
      default: br_taken = 1'b0;  // 010 and 011 are not branch encodings
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle OTTER control: fetch/execute/writeback FSM plus the PC register.
module pc_sequencer
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  OPCODE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] RS1,
  input  logic [31:0] RS2,
  input  logic        IMEM_VALID,
  input  logic [31:0] PC_DIN,
  output logic [1:0]  PC_SOURCE,
  output logic [31:0] PC,
  output logic [31:0] PC_four,
  output logic        IMEM_RDEN,
  output logic        IR_LATCH,
  output logic        PC_WRITE
);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic        br_taken;
  pc_src_t     pc_source_next;
  logic        rden_next, latch_next, pc_write_next;

  branch_cond_gen u_branch_cond_gen (
    .RS1      (RS1),
    .RS2      (RS2),
    .FUNCT3   (FUNCT3),
    .br_taken (br_taken)
  );

  // Strobes depend on IMEM_VALID and the latched opcode in the same cycle,
  // so they are decoded from the current state rather than registered.
  always_comb begin
    state_next     = state_reg;
    pc_source_next = PCSRC_PC4;
    rden_next      = 1'b0;
    latch_next     = 1'b0;
    pc_write_next  = 1'b0;
    case (state_reg)
      ST_INIT: state_next = ST_FETCH;
      ST_FETCH: begin
        rden_next = 1'b1;
        if (IMEM_VALID) begin
          latch_next = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (OPCODE)
          OP_JAL:    pc_source_next = PCSRC_JAL;
          OP_JALR:   pc_source_next = PCSRC_JALR;
          OP_BRANCH: pc_source_next = br_taken ? PCSRC_BRANCH : PCSRC_PC4;
          default:   pc_source_next = PCSRC_PC4;
        endcase
        if (OPCODE == OP_LOAD) begin
          state_next = ST_WB;
        end else begin
          pc_write_next = 1'b1;
          state_next    = ST_FETCH;
        end
      end
      ST_WB: begin
        pc_write_next = 1'b1;
        state_next    = ST_FETCH;
      end
      default: state_next = ST_INIT;
    endcase
  end

  // Reset silences every strobe so an in-flight instruction has no effect.
  assign PC_SOURCE = RST ? 2'b00 : pc_source_next;
  assign IMEM_RDEN = rden_next & ~RST;
  assign IR_LATCH  = latch_next & ~RST;
  assign PC_WRITE  = pc_write_next & ~RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_INIT;
      pc_reg    <= RESET_VECTOR;
    end else begin
      state_reg <= state_next;
      if (pc_write_next) begin
        pc_reg <= {PC_DIN[31:2], 2'b00};
      end
    end
  end

  assign PC      = pc_reg;
  assign PC_four = pc_reg + 32'd4;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;
  import otter_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [6:0]  OPCODE;
  logic [2:0]  FUNCT3;
  logic [31:0] RS1, RS2;
  logic        IMEM_VALID;
  logic [31:0] PC_DIN;
  logic [1:0]  PC_SOURCE;
  logic [31:0] PC, PC_four;
  logic        IMEM_RDEN, IR_LATCH, PC_WRITE;

  int pass_cnt = 0;
  int total_cnt = 0;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0100)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .OPCODE     (OPCODE),
    .FUNCT3     (FUNCT3),
    .RS1        (RS1),
    .RS2        (RS2),
    .IMEM_VALID (IMEM_VALID),
    .PC_DIN     (PC_DIN),
    .PC_SOURCE  (PC_SOURCE),
    .PC         (PC),
    .PC_four    (PC_four),
    .IMEM_RDEN  (IMEM_RDEN),
    .IR_LATCH   (IR_LATCH),
    .PC_WRITE   (PC_WRITE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %s observed=%h expected=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 2 time units after the edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // From FETCH: present a valid instruction word, confirm the latch strobe, move to EXEC.
  task automatic fetch(input string tag);
    IMEM_VALID = 1'b1;
    #1;
    check({tag, "_ir_latch"}, 32'(IR_LATCH), 32'd1);
    tick();
    IMEM_VALID = 1'b0;
  endtask

  initial begin
    RST = 1'b1; OPCODE = 7'd0; FUNCT3 = 3'd0; RS1 = 32'd0; RS2 = 32'd0;
    IMEM_VALID = 1'b1; PC_DIN = 32'hDEAD_BEEF;
    tick();
    tick();
    check("rst_pc", PC, 32'h0000_0100);
    check("rst_state", 32'(dut.state_reg), 32'(ST_INIT));
    check("rst_rden", 32'(IMEM_RDEN), 32'd0);
    check("rst_latch", 32'(IR_LATCH), 32'd0);
    check("rst_pcwrite", 32'(PC_WRITE), 32'd0);
    check("rst_pcsrc", 32'(PC_SOURCE), 32'd0);

    RST = 1'b0; IMEM_VALID = 1'b0;
    #1;
    check("init_rden", 32'(IMEM_RDEN), 32'd0);
    check("init_pcwrite", 32'(PC_WRITE), 32'd0);
    tick();
    check("fetch_state", 32'(dut.state_reg), 32'(ST_FETCH));

    for (int i = 0; i < 3; i++) begin
      check("stall_rden", 32'(IMEM_RDEN), 32'd1);
      check("stall_latch", 32'(IR_LATCH), 32'd0);
      check("stall_pc", PC, 32'h0000_0100);
      tick();
    end

    // BEQ taken
    fetch("beq");
    OPCODE = OP_BRANCH; FUNCT3 = 3'b000; RS1 = 32'd5; RS2 = 32'd5; PC_DIN = 32'h0000_0200;
    #1;
    check("beq_pcsrc", 32'(PC_SOURCE), 32'h2);
    check("beq_pcwrite", 32'(PC_WRITE), 32'd1);
    check("beq_rden", 32'(IMEM_RDEN), 32'd0);
    tick();
    check("beq_pc", PC, 32'h0000_0200);
    check("beq_fetch_rden", 32'(IMEM_RDEN), 32'd1);

    // BLT signed: -1 < 1 taken
    fetch("blt");
    OPCODE = OP_BRANCH; FUNCT3 = 3'b100; RS1 = 32'hFFFF_FFFF; RS2 = 32'd1; PC_DIN = 32'h0000_0240;
    #1;
    check("blt_pcsrc", 32'(PC_SOURCE), 32'h2);
    tick();
    check("blt_pc", PC, 32'h0000_0240);

    // BLTU: 0xFFFFFFFF < 1 is false
    fetch("bltu");
    FUNCT3 = 3'b110; PC_DIN = 32'h0000_0244;
    #1;
    check("bltu_pcsrc", 32'(PC_SOURCE), 32'h0);
    tick();
    check("bltu_pc", PC, 32'h0000_0244);

    // funct3 010 is never taken even with equal operands
    fetch("f3_010");
    FUNCT3 = 3'b010; RS1 = 32'd7; RS2 = 32'd7; PC_DIN = 32'h0000_0248;
    #1;
    check("f3_010_pcsrc", 32'(PC_SOURCE), 32'h0);
    tick();

    // LOAD goes through WB, PC advances by 4
    fetch("load");
    OPCODE = OP_LOAD; PC_DIN = 32'h0000_024C;
    #1;
    check("load_pc4", PC_four, 32'h0000_024C);
    check("load_exec_pcwrite", 32'(PC_WRITE), 32'd0);
    tick();
    check("load_wb_state", 32'(dut.state_reg), 32'(ST_WB));
    check("load_wb_pcwrite", 32'(PC_WRITE), 32'd1);
    check("load_wb_pcsrc", 32'(PC_SOURCE), 32'h0);
    tick();
    check("load_pc", PC, 32'h0000_024C);

    // JAL to the top of memory; low bits of PC_DIN are cleared
    fetch("jal");
    OPCODE = OP_JAL; PC_DIN = 32'hFFFF_FFFF;
    #1;
    check("jal_pcsrc", 32'(PC_SOURCE), 32'h3);
    tick();
    check("jal_pc", PC, 32'hFFFF_FFFC);
    check("wrap_pc4", PC_four, 32'h0000_0000);

    fetch("jalr");
    OPCODE = OP_JALR; PC_DIN = 32'h0000_0303;
    #1;
    check("jalr_pcsrc", 32'(PC_SOURCE), 32'h1);
    tick();
    check("jalr_pc", PC, 32'h0000_0300);

    fetch("illegal");
    OPCODE = 7'h7F; PC_DIN = 32'h0000_0304;
    #1;
    check("illegal_pcsrc", 32'(PC_SOURCE), 32'h0);
    check("illegal_pcwrite", 32'(PC_WRITE), 32'd1);
    tick();
    check("illegal_pc", PC, 32'h0000_0304);

    // Reset in EXEC discards the jump
    fetch("rst_exec");
    OPCODE = OP_JAL; PC_DIN = 32'h0000_0500; RST = 1'b1;
    #1;
    check("rst_exec_pcwrite", 32'(PC_WRITE), 32'd0);
    tick();
    check("rst_exec_pc", PC, 32'h0000_0100);
    check("rst_exec_state", 32'(dut.state_reg), 32'(ST_INIT));
    RST = 1'b0;
    tick();
    check("rst_exec_fetch", 32'(dut.state_reg), 32'(ST_FETCH));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
